axilite_timer_seq: RTL and testbench
====================================

AXILITE_TIMER_SEQ -- requirements
Module: axilite_timer_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the AXI-Lite address width.
REQ-002 SHALL have parameter BASEADDR, default 0, the timer register base address.
REQ-003 SHALL have port axi_aclk, input, 1, the sole clock.
REQ-004 SHALL have port axi_aresetn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a sequence-request pulse.
REQ-006 SHALL have port load_val, input, 32, the timer load value.
REQ-007 SHALL have port csr_val, input, 32, the base control word.
REQ-008 SHALL have port busy, output, 1, high while a sequence runs.
REQ-009 SHALL have port done, output, 1, a one-cycle success pulse.
REQ-010 SHALL have port err, output, 1, a sticky failure flag.
REQ-011 SHALL have ports aw_addr (output, ADDR_WIDTH), aw_valid (output, 1) and aw_ready (input, 1), forming the write-address channel.
REQ-012 SHALL have ports w_data (output, 32), w_strb (output, 4), w_valid (output, 1) and w_ready (input, 1), forming the write-data channel.
REQ-013 SHALL have ports b_resp (input, 2), b_valid (input, 1) and b_ready (output, 1), forming the write-response channel.
REQ-014 SHALL have ports ar_addr (output, ADDR_WIDTH), ar_valid (output, 1) and ar_ready (input, 1), forming the read-address channel.
REQ-015 SHALL have ports r_data (input, 32), r_resp (input, 2), r_valid (input, 1) and r_ready (output, 1), forming the read-data channel.

Function
REQ-016 SHALL implement FSM IDLE -> WR_TLR -> WR_LOAD -> WR_ENA -> IDLE: TLR=BASEADDR+0x4 gets load_val; CSR=BASEADDR+0x0 gets csr_val|LOAD (bit5), then (csr_val&~LOAD)|ENA (bit7).
REQ-017 SHALL leave IDLE only on start=1; start while busy SHALL be ignored; busy SHALL rise the cycle after start.
REQ-018 SHALL assert aw_valid and w_valid in the same cycle at write entry, drop each independently on its ready, and never drop either before its ready (AXI rule).
REQ-019 SHALL assert b_ready only after both AW and W handshakes; if aw_ready and w_ready arrive in the same cycle, b_ready SHALL assert the next cycle.
REQ-020 SHALL drive w_strb as 4'hF; addresses and data SHALL remain stable while valid is high.
REQ-021 SHALL treat b_resp!=OKAY as failure: set err, return to IDLE, done stays 0.
REQ-022 SHALL run an 8-bit timeout counter, cleared at each phase entry; when the count reaches SEQ_TIMEOUT with a handshake still pending, all valids SHALL drop, err SHALL set, and the FSM SHALL go to IDLE.
REQ-023 SHALL pulse done and drop busy in the same cycle as the last write completes; err SHALL clear on the next accepted start.

Reset
REQ-024 SHALL, while axi_aresetn=0, immediately drive every valid/ready output, busy, done and err to 0, all address/data outputs to 0 and the FSM to IDLE, including mid-transaction.

Configuration
REQ-025 SHALL, when AXILITE_TIMER_SEQ_READBACK_EN is defined, follow each B handshake with a read of the same address (ar_valid until ar_ready, then r_ready until r_valid); r_resp!=OKAY or r_data!=written value SHALL set err; the WR_LOAD readback SHALL compare with bit5 masked.
REQ-026 SHALL, without AXILITE_TIMER_SEQ_READBACK_EN, tie ar_valid, r_ready and ar_addr to 0 and omit the readback states.

Structure
REQ-027 SHALL place the state enum, the TLR/CSR offsets, the LOAD/ENA bit indices, SEQ_TIMEOUT=255 and the OKAY encoding in package axilite_timer_seq_pkg.
REQ-028 SHALL implement one write transaction in sub-module axilite_wr_txn, with inputs req/addr/data and outputs ack/resp_err/timeout, instantiated once.

Verification
REQ-029 SHALL verify: start with load_val=0x0000_1000, csr_val=0x12 -> writes 0x4=0x1000, 0x0=0x32, 0x0=0x92; done pulses once.
REQ-030 SHALL verify: aw_ready 3 cycles before w_ready, and the reverse -> each valid held until its own ready; b_ready only after both.
REQ-031 SHALL verify: b_resp=2'b10 on the WR_LOAD write -> err=1, no WR_ENA write, done=0.
REQ-032 SHALL verify: aw_ready held 0 for 300 cycles -> err at count 255, valids drop, FSM in IDLE.
REQ-033 SHALL verify: axi_aresetn asserted while w_valid=1, then a new start -> outputs 0 at once; the full sequence completes cleanly.
REQ-034 SHALL verify: with the macro defined, TLR readback r_data=0x0FFF -> err=1; with r_data matching -> done pulses.

Source files
------------

// File: rtl/axilite_timer_seq_pkg.sv
// -----------------------------------------------------------------------------
// axilite_timer_seq_pkg
// Shared definitions for the AXI-Lite timer programming sequencer: FSM state
// encoding, timer register offsets, CSR bit positions, the handshake timeout
// and the AXI OKAY response code.
// Optional feature macro: AXILITE_TIMER_SEQ_READBACK_EN adds the read-back
// states to the state enum.
// -----------------------------------------------------------------------------
package axilite_timer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_TLR,
    ST_WR_LOAD,
    ST_WR_ENA
`ifdef AXILITE_TIMER_SEQ_READBACK_EN
    ,
    ST_RD_TLR,
    ST_RD_LOAD,
    ST_RD_ENA
`endif
  } seq_state_e;

  // Which of the three register writes a state belongs to.
  typedef enum logic [1:0] {
    PH_NONE,
    PH_TLR,
    PH_LOAD,
    PH_ENA
  } seq_phase_e;

  localparam logic [31:0] CSR_OFFSET  = 32'h0000_0000;
  localparam logic [31:0] TLR_OFFSET  = 32'h0000_0004;
  localparam int          LOAD_BIT    = 5;
  localparam int          ENA_BIT     = 7;
  localparam logic [31:0] LOAD_MASK   = 32'h1 << LOAD_BIT;
  localparam logic [31:0] ENA_MASK    = 32'h1 << ENA_BIT;
  localparam logic [7:0]  SEQ_TIMEOUT = 8'd255;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;

  function automatic seq_phase_e phase_of(input seq_state_e s);
    case (s)
      ST_WR_TLR:  return PH_TLR;
      ST_WR_LOAD: return PH_LOAD;
      ST_WR_ENA:  return PH_ENA;
`ifdef AXILITE_TIMER_SEQ_READBACK_EN
      ST_RD_TLR:  return PH_TLR;
      ST_RD_LOAD: return PH_LOAD;
      ST_RD_ENA:  return PH_ENA;
`endif
      default:    return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/axilite_wr_txn.sv
// -----------------------------------------------------------------------------
// axilite_wr_txn
// Runs one AXI-Lite write transaction per req pulse. AW and W are raised
// together, each dropped on its own ready; b_ready follows once both
// handshakes are done. An 8-bit counter, cleared on req, aborts the
// transaction when it reaches SEQ_TIMEOUT with a handshake still pending.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req, addr, data            start pulse and the address/data to write
//   ack                        B handshake this cycle (combinational)
//   resp_err                   ack with a non-OKAY response
//   timeout                    transaction abandoned this cycle
//   aw_*, w_*, b_*             AXI-Lite write channels
// -----------------------------------------------------------------------------
module axilite_wr_txn
  import axilite_timer_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data,
  output logic                  ack,
  output logic                  resp_err,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] aw_addr,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [31:0]           w_data,
  output logic [3:0]            w_strb,
  output logic                  w_valid,
  input  logic                  w_ready,
  input  logic [1:0]            b_resp,
  input  logic                  b_valid,
  output logic                  b_ready
);

  logic                  r_active;
  logic                  r_aw_valid;
  logic                  r_w_valid;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_b_ready;
  logic [7:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;

  assign w_aw_hs  = r_aw_valid & aw_ready;
  assign w_w_hs   = r_w_valid & w_ready;
  assign w_b_hs   = r_b_ready & b_valid;

  assign ack      = w_b_hs;
  assign resp_err = w_b_hs & (b_resp != RESP_OKAY);
  assign timeout  = r_active & (r_cnt == SEQ_TIMEOUT) & ~w_b_hs;

  assign aw_addr  = r_addr;
  assign aw_valid = r_aw_valid;
  assign w_data   = r_data;
  assign w_strb   = 4'hF;
  assign w_valid  = r_w_valid;
  assign b_ready  = r_b_ready;

  // NOTE: sequential state uses non-blocking assignments; within the block the
  // last assignment wins, so the abort and the new-request branches sit last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_b_ready  <= 1'b0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      if (r_active) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_aw_hs) begin
          r_aw_valid <= 1'b0;
          r_aw_done  <= 1'b1;
        end
        if (w_w_hs) begin
          r_w_valid <= 1'b0;
          r_w_done  <= 1'b1;
        end
        // Both address and data accepted (now or earlier): open the B channel.
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) r_b_ready <= 1'b1;
        if (w_b_hs) begin
          r_b_ready <= 1'b0;
          r_active  <= 1'b0;
        end
        if (timeout) begin
          r_aw_valid <= 1'b0;
          r_w_valid  <= 1'b0;
          r_b_ready  <= 1'b0;
          r_active   <= 1'b0;
        end
      end
      if (req) begin
        r_active   <= 1'b1;
        r_aw_valid <= 1'b1;
        r_w_valid  <= 1'b1;
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
        r_b_ready  <= 1'b0;
        r_cnt      <= '0;
        r_addr     <= addr;
        r_data     <= data;
      end
    end
  end

endmodule

// File: rtl/axilite_timer_seq.sv
// -----------------------------------------------------------------------------
// axilite_timer_seq
// On a start pulse, programs an AXI-Lite timer: TLR <= load_val, then
// CSR <= csr_val | LOAD, then CSR <= (csr_val & ~LOAD) | ENA. done pulses and
// busy falls together when the last step completes; err is sticky until the
// next accepted start.
// Optional feature macro: AXILITE_TIMER_SEQ_READBACK_EN reads back every
// written register (LOAD bit ignored on the CSR load step) and flags err on a
// mismatch or a non-OKAY read response. Without it the AR/R outputs are tied 0.
// Ports:
//   axi_aclk, axi_aresetn      clock, async active-low reset
//   start, load_val, csr_val   sequence request and the values to program
//   busy, done, err            sequence status
//   aw_*, w_*, b_*, ar_*, r_*  AXI-Lite master channels
// -----------------------------------------------------------------------------
module axilite_timer_seq
  import axilite_timer_seq_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASEADDR   = '0
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  start,
  input  logic [31:0]           load_val,
  input  logic [31:0]           csr_val,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] aw_addr,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [31:0]           w_data,
  output logic [3:0]            w_strb,
  output logic                  w_valid,
  input  logic                  w_ready,
  input  logic [1:0]            b_resp,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  input  logic [31:0]           r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_valid,
  output logic                  r_ready
);

  localparam logic [ADDR_WIDTH-1:0] TLR_ADDR = BASEADDR + ADDR_WIDTH'(TLR_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] CSR_ADDR = BASEADDR + ADDR_WIDTH'(CSR_OFFSET);

  seq_state_e r_state;
  seq_state_e w_state_nx;
  logic [31:0] r_csr;
  logic        r_err;
  logic        r_done;

  seq_phase_e            w_phase;
  logic                  w_req;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [31:0]           w_req_data;
  logic                  w_ack;
  logic                  w_resp_err;
  logic                  w_timeout;
  logic                  w_set_err;
  logic                  w_set_done;
  logic                  w_adv;

  assign w_phase = phase_of(r_state);
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign err     = r_err;

  axilite_wr_txn #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_txn (
    .clk      (axi_aclk),
    .rst_n    (axi_aresetn),
    .req      (w_req),
    .addr     (w_req_addr),
    .data     (w_req_data),
    .ack      (w_ack),
    .resp_err (w_resp_err),
    .timeout  (w_timeout),
    .aw_addr  (aw_addr),
    .aw_valid (aw_valid),
    .aw_ready (aw_ready),
    .w_data   (w_data),
    .w_strb   (w_strb),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .b_resp   (b_resp),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
  );

`ifdef AXILITE_TIMER_SEQ_READBACK_EN
  logic                  r_ar_valid;
  logic                  r_r_ready;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [7:0]            r_rd_cnt;
  logic [31:0]           r_exp;
  logic                  w_rd_start;
  logic                  w_rd_hs;
  logic                  w_rd_bad;
  logic                  w_rd_timeout;
  logic [31:0]           w_rd_mask;

  // The timer clears LOAD by itself, so the CSR load step ignores that bit.
  assign w_rd_mask    = (w_phase == PH_LOAD) ? ~LOAD_MASK : '1;
  assign w_rd_hs      = r_r_ready & r_valid;
  assign w_rd_bad     = (r_resp != RESP_OKAY) | (((r_data ^ r_exp) & w_rd_mask) != '0);
  assign w_rd_timeout = (r_ar_valid | r_r_ready) & (r_rd_cnt == SEQ_TIMEOUT) & ~w_rd_hs;

  assign ar_valid = r_ar_valid;
  assign ar_addr  = r_ar_addr;
  assign r_ready  = r_r_ready;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_ar_valid <= 1'b0;
      r_r_ready  <= 1'b0;
      r_ar_addr  <= '0;
      r_rd_cnt   <= '0;
      r_exp      <= '0;
    end else begin
      if (w_req) r_exp <= w_req_data;
      if (r_ar_valid | r_r_ready) r_rd_cnt <= r_rd_cnt + 8'd1;
      if (r_ar_valid & ar_ready) begin
        r_ar_valid <= 1'b0;
        r_r_ready  <= 1'b1;
      end
      if (w_rd_hs) r_r_ready <= 1'b0;
      if (w_rd_timeout) begin
        r_ar_valid <= 1'b0;
        r_r_ready  <= 1'b0;
      end
      if (w_rd_start) begin
        r_ar_valid <= 1'b1;
        r_rd_cnt   <= '0;
        r_ar_addr  <= (w_phase == PH_TLR) ? TLR_ADDR : CSR_ADDR;
      end
    end
  end
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{ar_ready, r_data, r_resp, r_valid};
  assign ar_valid    = 1'b0;
  assign ar_addr     = '0;
  assign r_ready     = 1'b0;
`endif

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    w_req      = 1'b0;
    w_req_addr = CSR_ADDR;
    w_req_data = r_csr | LOAD_MASK;
    w_set_err  = 1'b0;
    w_set_done = 1'b0;
    w_adv      = 1'b0;
`ifdef AXILITE_TIMER_SEQ_READBACK_EN
    w_rd_start = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nx = ST_WR_TLR;
          w_req      = 1'b1;
          w_req_addr = TLR_ADDR;
          w_req_data = load_val;
        end
      end
      ST_WR_TLR, ST_WR_LOAD, ST_WR_ENA: begin
        if (w_timeout || (w_ack && w_resp_err)) begin
          w_state_nx = ST_IDLE;
          w_set_err  = 1'b1;
        end else if (w_ack) begin
`ifdef AXILITE_TIMER_SEQ_READBACK_EN
          w_rd_start = 1'b1;
          case (w_phase)
            PH_TLR:  w_state_nx = ST_RD_TLR;
            PH_LOAD: w_state_nx = ST_RD_LOAD;
            default: w_state_nx = ST_RD_ENA;
          endcase
`else
          w_adv = 1'b1;
`endif
        end
      end
`ifdef AXILITE_TIMER_SEQ_READBACK_EN
      ST_RD_TLR, ST_RD_LOAD, ST_RD_ENA: begin
        if (w_rd_timeout || (w_rd_hs && w_rd_bad)) begin
          w_state_nx = ST_IDLE;
          w_set_err  = 1'b1;
        end else if (w_rd_hs) begin
          w_adv = 1'b1;
        end
      end
`endif
      default: w_state_nx = ST_IDLE;
    endcase

    // A step finished cleanly: launch the next write or finish the sequence.
    if (w_adv) begin
      case (w_phase)
        PH_TLR: begin
          w_state_nx = ST_WR_LOAD;
          w_req      = 1'b1;
        end
        PH_LOAD: begin
          w_state_nx = ST_WR_ENA;
          w_req      = 1'b1;
          w_req_data = (r_csr & ~LOAD_MASK) | ENA_MASK;
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_set_done = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state <= ST_IDLE;
      r_csr   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= w_set_done;
      if (r_state == ST_IDLE && start) begin
        r_csr <= csr_val;
        r_err <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axilite_timer_seq.sv
// -----------------------------------------------------------------------------
// tb_axilite_timer_seq
// Directed bench for axilite_timer_seq. The bench plays the AXI-Lite slave
// from tasks in one initial block; inputs change and outputs are sampled on
// the falling clock edge. Read-back steps are exercised when
// AXILITE_TIMER_SEQ_READBACK_EN is defined.
// -----------------------------------------------------------------------------
module tb_axilite_timer_seq;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn;
  logic        start;
  logic [31:0] load_val, csr_val;
  logic        busy, done, err;
  logic [31:0] aw_addr, w_data, ar_addr, r_data;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [3:0]  w_strb;
  logic [1:0]  b_resp, r_resp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 axi_aclk = ~axi_aclk;

  axilite_timer_seq #(.ADDR_WIDTH(32), .BASEADDR(BASE)) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .start       (start),
    .load_val    (load_val),
    .csr_val     (csr_val),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .aw_addr     (aw_addr),
    .aw_valid    (aw_valid),
    .aw_ready    (aw_ready),
    .w_data      (w_data),
    .w_strb      (w_strb),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .b_resp      (b_resp),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .ar_addr     (ar_addr),
    .ar_valid    (ar_valid),
    .ar_ready    (ar_ready),
    .r_data      (r_data),
    .r_resp      (r_resp),
    .r_valid     (r_valid),
    .r_ready     (r_ready)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Slave side of one write. aw_lat/w_lat: cycles after valid before ready.
  task automatic serve_write(input int aw_lat, input int w_lat, input logic [1:0] resp,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data,
                             input string tag);
    int  c;
    bit  aw_done, w_done;
    c = 0;
    while (!aw_valid && c < 20) begin
      @(negedge axi_aclk);
      c++;
    end
    check({tag, " aw_valid rise"}, 32'(aw_valid), 32'd1);
    check({tag, " w_valid rise"},  32'(w_valid),  32'd1);
    check({tag, " aw_addr"},       aw_addr,       exp_addr);
    check({tag, " w_data"},        w_data,        exp_data);
    check({tag, " w_strb"},        32'(w_strb),   32'hF);
    aw_done = 1'b0;
    w_done  = 1'b0;
    c = 0;
    while (!(aw_done && w_done) && c < 40) begin
      check({tag, " b_ready early"}, 32'(b_ready), 32'd0);
      if (!aw_done) begin
        check({tag, " aw_valid held"}, 32'(aw_valid), 32'd1);
        check({tag, " aw_addr stable"}, aw_addr, exp_addr);
      end
      if (!w_done) begin
        check({tag, " w_valid held"}, 32'(w_valid), 32'd1);
        check({tag, " w_data stable"}, w_data, exp_data);
      end
      aw_ready = !aw_done && (c >= aw_lat);
      w_ready  = !w_done && (c >= w_lat);
      if (aw_ready) aw_done = 1'b1;
      if (w_ready)  w_done  = 1'b1;
      @(negedge axi_aclk);
      c++;
    end
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    check({tag, " aw_valid dropped"}, 32'(aw_valid), 32'd0);
    check({tag, " w_valid dropped"},  32'(w_valid),  32'd0);
    check({tag, " b_ready"},          32'(b_ready),  32'd1);
    b_valid = 1'b1;
    b_resp  = resp;
    @(negedge axi_aclk);
    b_valid = 1'b0;
    b_resp  = 2'b00;
  endtask

  // Slave side of one read: ar_ready on first sight of ar_valid, data next cycle.
  task automatic serve_read(input logic [31:0] exp_addr, input logic [31:0] rdata, input string tag);
    int c;
    c = 0;
    while (!ar_valid && c < 20) begin
      @(negedge axi_aclk);
      c++;
    end
    check({tag, " ar_valid"}, 32'(ar_valid), 32'd1);
    check({tag, " ar_addr"},  ar_addr,       exp_addr);
    check({tag, " r_ready early"}, 32'(r_ready), 32'd0);
    ar_ready = 1'b1;
    @(negedge axi_aclk);
    ar_ready = 1'b0;
    check({tag, " ar_valid dropped"}, 32'(ar_valid), 32'd0);
    check({tag, " r_ready"}, 32'(r_ready), 32'd1);
    r_valid = 1'b1;
    r_data  = rdata;
    r_resp  = 2'b00;
    @(negedge axi_aclk);
    r_valid = 1'b0;
    r_data  = '0;
  endtask

  // Full successful sequence; start held start_cycles cycles (extra ones land while busy).
  task automatic run_seq(input logic [31:0] ld, input logic [31:0] csr, input int aw_lat,
                         input int w_lat, input int start_cycles, input string tag);
    logic [31:0] v_load, v_ena;
    v_load = csr | 32'h20;
    v_ena  = (csr & ~32'h20) | 32'h80;
    load_val = ld;
    csr_val  = csr;
    start    = 1'b1;
    repeat (start_cycles) @(negedge axi_aclk);
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " err cleared"}, 32'(err), 32'd0);
`ifndef AXILITE_TIMER_SEQ_READBACK_EN
    check({tag, " read channel idle"}, {ar_addr[29:0], ar_valid, r_ready}, 32'd0);
`endif
    serve_write(aw_lat, w_lat, 2'b00, BASE + 32'h4, ld, {tag, " TLR"});
`ifdef AXILITE_TIMER_SEQ_READBACK_EN
    serve_read(BASE + 32'h4, ld, {tag, " rd TLR"});
`endif
    check({tag, " no early done"}, 32'(done), 32'd0);
    serve_write(aw_lat, w_lat, 2'b00, BASE, v_load, {tag, " CSR load"});
`ifdef AXILITE_TIMER_SEQ_READBACK_EN
    serve_read(BASE, v_load & ~32'h20, {tag, " rd CSR load"});
`endif
    serve_write(aw_lat, w_lat, 2'b00, BASE, v_ena, {tag, " CSR ena"});
`ifdef AXILITE_TIMER_SEQ_READBACK_EN
    serve_read(BASE, v_ena, {tag, " rd CSR ena"});
`endif
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy low with done"}, 32'(busy), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
    @(negedge axi_aclk);
    check({tag, " done one pulse"}, 32'(done), 32'd0);
    check({tag, " stays idle"}, {29'd0, busy, aw_valid, w_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    axi_aresetn = 1'b0;
    start = 1'b0;  load_val = '0; csr_val = '0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;

    // Reset state
    repeat (3) @(negedge axi_aclk);
    check("reset flags", {24'd0, busy, done, err, aw_valid, w_valid, b_ready, ar_valid, r_ready}, 32'd0);
    check("reset aw_addr", aw_addr, 32'd0);
    check("reset w_data", w_data, 32'd0);
    check("reset ar_addr", ar_addr, 32'd0);
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);

    // Basic sequence: 0x4=0x1000, 0x0=0x32, 0x0=0x92
    run_seq(32'h0000_1000, 32'h0000_0012, 0, 0, 1, "basic");

    // AW accepted 3 cycles before W, then the reverse; second run also
    // holds start into the busy period, which must be ignored.
    run_seq(32'hDEAD_BEEF, 32'h0000_0041, 0, 3, 1, "aw first");
    run_seq(32'h0000_00FF, 32'hFFFF_FFFF, 3, 0, 2, "w first");

    // SLVERR on the CSR load write
    load_val = 32'h0000_0055;
    csr_val  = 32'h0000_0001;
    start    = 1'b1;
    @(negedge axi_aclk);
    start = 1'b0;
    serve_write(0, 0, 2'b00, BASE + 32'h4, 32'h0000_0055, "slverr TLR");
`ifdef AXILITE_TIMER_SEQ_READBACK_EN
    serve_read(BASE + 32'h4, 32'h0000_0055, "slverr rd TLR");
`endif
    serve_write(1, 0, 2'b10, BASE, 32'h0000_0021, "slverr CSR");
    check("slverr err", 32'(err), 32'd1);
    check("slverr busy", 32'(busy), 32'd0);
    check("slverr done", 32'(done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge axi_aclk);
      check("slverr no ENA write", {30'd0, aw_valid, done}, 32'd0);
    end
    check("slverr err sticky", 32'(err), 32'd1);

    // Timeout: aw_ready never comes. err appears on the 257th falling edge
    // after the start edge (counter 0..255 then one registering edge).
    load_val = 32'h0000_0100;
    csr_val  = 32'h0000_0002;
    start    = 1'b1;
    @(negedge axi_aclk);
    start   = 1'b0;
    w_ready = 1'b1;
    k = 1;
    while (!err && k < 300) begin
      @(negedge axi_aclk);
      w_ready = 1'b0;
      k++;
    end
    check("timeout cycle", 32'(k), 32'd257);
    check("timeout err", 32'(err), 32'd1);
    check("timeout valids", {29'd0, aw_valid, w_valid, b_ready}, 32'd0);
    check("timeout idle", {30'd0, busy, done}, 32'd0);

    // Reset mid-transaction, then a clean sequence
    load_val = 32'h1234_5678;
    csr_val  = 32'h0000_0010;
    start    = 1'b1;
    @(negedge axi_aclk);
    start = 1'b0;
    check("pre-reset w_valid", 32'(w_valid), 32'd1);
    #2 axi_aresetn = 1'b0;
    #1;
    check("async reset flags", {24'd0, busy, done, err, aw_valid, w_valid, b_ready, ar_valid, r_ready}, 32'd0);
    check("async reset aw_addr", aw_addr, 32'd0);
    check("async reset w_data", w_data, 32'd0);
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    run_seq(32'h0000_2000, 32'h0000_0003, 1, 2, 1, "after reset");

`ifdef AXILITE_TIMER_SEQ_READBACK_EN
    // TLR read-back returns the wrong value
    load_val = 32'h0000_1000;
    csr_val  = 32'h0000_0012;
    start    = 1'b1;
    @(negedge axi_aclk);
    start = 1'b0;
    serve_write(0, 0, 2'b00, BASE + 32'h4, 32'h0000_1000, "rb bad TLR");
    serve_read(BASE + 32'h4, 32'h0000_0FFF, "rb bad rd TLR");
    check("rb mismatch err", 32'(err), 32'd1);
    check("rb mismatch idle", {30'd0, busy, done}, 32'd0);
    @(negedge axi_aclk);
    check("rb mismatch no write", 32'(aw_valid), 32'd0);
    run_seq(32'h0000_1000, 32'h0000_0012, 0, 0, 1, "rb match");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
